donut_angle_stepper: RTL and testbench

- Upstream feeder for the donut renderer. Holds the two rotation angles A and B as cosine/sine pairs in Q2.14 fixed point.
- Once per frame, during vblank, it advances each pair by a Minsky shift-rotation, then renormalises each pair's magnitude with one Newton step built from a shared serial multiplier.
- New values commit atomically, so the renderer never sees a half-updated set.

---
 rtl/donut_pkg.sv | 36 +++
 rtl/mul_serial16.sv | 66 ++++++
 rtl/donut_angle_stepper.sv | 193 +++++++++++++++++++
 tb/tb_donut_angle_stepper.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/donut_pkg.sv
// Shared definitions for the donut angle stepper: Q2.14 constants, FSM state
// encoding, pair selection and the 16-bit saturation helper.
package donut_pkg;

    // Q2.14 representations of 1.0 and 3.0
    localparam logic signed [15:0] ONE   = 16'sd16384;
    localparam int                 THREE = 49152;

    typedef enum logic [2:0] {
        IDLE,
        ROT,
        MUL_CC,
        MUL_SS,
        CALC_K,
        MUL_CK,
        MUL_SK,
        COMMIT
    } state_e;

    typedef enum logic {
        PAIR_A = 1'b0,
        PAIR_B = 1'b1
    } pair_e;

    // Clamp a wide signed intermediate into the signed 16-bit range
    function automatic logic signed [15:0] sat16(input logic signed [47:0] x);
        if (x > 48'sd32767) begin
            return 16'sh7fff;
        end else if (x < -48'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/mul_serial16.sv
// Signed 16x16 -> 32 shift-add multiplier, one multiplier bit per cycle.
// The launch edge latches the operands and already folds in bit 0, so the
// full product is on p in the same cycle done pulses, MUL_CYCLES cycles
// after start. Bit 15 carries weight -2^15 (two's complement), so its
// partial product is subtracted. A start while running restarts it.
module mul_serial16 #(
    parameter int MUL_CYCLES = 16
) (
    input  logic               clk48,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] p,
    output logic               done
);

    localparam int IW = $clog2(MUL_CYCLES);

    logic signed [31:0] mcand;
    logic        [15:0] mplier;
    logic      [IW-1:0] idx;
    logic               running;
    logic signed [31:0] shifted;
    logic signed [31:0] term;

    // Partial product for the multiplier bit selected by idx
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        term    = '0;
        shifted = mcand <<< idx;
        if (mplier[idx]) begin
            term = (idx == IW'(MUL_CYCLES - 1)) ? -shifted : shifted;
        end
    end

    // Operand latch, accumulation and completion pulse
    always_ff @(posedge clk48 or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            p       <= '0;
            idx     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= 32'(a);
                mplier  <= b;
                p       <= b[0] ? 32'(a) : '0;
                idx     <= IW'(1);
                running <= 1'b1;
            end else if (running) begin
                p   <= p + term;
                idx <= idx + 1'b1;
                if (idx == IW'(MUL_CYCLES - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/donut_angle_stepper.sv
// Per-frame rotation of the two donut angles. On an enabled frame_start the
// cos/sin pairs are copied into working registers, rotated by a Minsky step,
// renormalised with one Newton step (k = (3 - |v|^2) / 2) using a shared
// serial multiplier, and then all four outputs are loaded in one edge.
module donut_angle_stepper
    import donut_pkg::*;
#(
    parameter int SHIFT_A    = 5,
    parameter int SHIFT_B    = 6,
    parameter int MUL_CYCLES = 16
) (
    input  logic               clk48,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               enable,
    output logic signed [15:0] cos_a,
    output logic signed [15:0] sin_a,
    output logic signed [15:0] cos_b,
    output logic signed [15:0] sin_b,
    output logic               busy,
    output logic               update
);

    state_e             state, next_state;
    logic               entered;
    pair_e              pair;

    logic signed [15:0] wc [2];
    logic signed [15:0] ws [2];
    logic signed [15:0] rot_c [2];
    logic signed [15:0] rot_s [2];
    logic signed [31:0] p_reg, q_reg;
    logic signed [15:0] k_reg;

    logic signed [32:0] pq_sum;
    logic signed [32:0] m_val;
    logic signed [33:0] k_half;
    logic signed [15:0] k_next;
    logic signed [15:0] prod_sat;

    logic               mul_start;
    logic signed [15:0] mul_a, mul_b;
    logic signed [31:0] mul_p;
    logic               mul_done;

    mul_serial16 #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk48 (clk48),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p),
        .done  (mul_done)
    );

    // State register; entered flags the first cycle of every state
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            entered <= 1'b0;
        end else begin
            state   <= next_state;
            entered <= (next_state != state);
        end
    end

    // Next-state sequencing: ROT, then the MUL/CALC chain for A then B
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_start && enable) next_state = ROT;
            ROT:     next_state = MUL_CC;
            MUL_CC:  if (mul_done) next_state = MUL_SS;
            MUL_SS:  if (mul_done) next_state = CALC_K;
            CALC_K:  next_state = MUL_CK;
            MUL_CK:  if (mul_done) next_state = MUL_SK;
            MUL_SK:  if (mul_done) next_state = (pair == PAIR_A) ? MUL_CC : COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Multiplier launch and operand selection for the current MUL state
    always_comb begin
        mul_start = 1'b0;
        mul_a     = wc[pair];
        mul_b     = wc[pair];
        case (state)
            MUL_CC: mul_start = entered;
            MUL_SS: begin
                mul_start = entered;
                mul_a     = ws[pair];
                mul_b     = ws[pair];
            end
            MUL_CK: begin
                mul_start = entered;
                mul_b     = k_reg;
            end
            MUL_SK: begin
                mul_start = entered;
                mul_a     = ws[pair];
                mul_b     = k_reg;
            end
            default: ;
        endcase
    end

    // Minsky rotation for both pairs; the sine uses the already-updated cosine
    always_comb begin
        rot_c[PAIR_A] = sat16(48'(wc[PAIR_A]) - 48'(ws[PAIR_A] >>> SHIFT_A));
        rot_s[PAIR_A] = sat16(48'(ws[PAIR_A]) + 48'(rot_c[PAIR_A] >>> SHIFT_A));
        rot_c[PAIR_B] = sat16(48'(wc[PAIR_B]) - 48'(ws[PAIR_B] >>> SHIFT_B));
        rot_s[PAIR_B] = sat16(48'(ws[PAIR_B]) + 48'(rot_c[PAIR_B] >>> SHIFT_B));
    end

    // Newton factor k = (3 - (c^2 + s^2)) / 2 in Q2.14, kept non-negative
    always_comb begin
        pq_sum = 33'(p_reg) + 33'(q_reg);
        m_val  = pq_sum >>> 14;
        k_half = (34'(THREE) - 34'(m_val)) >>> 1;
        if (k_half < 34'sd0) begin
            k_next = '0;
        end else if (k_half > 34'sd32767) begin
            k_next = 16'sh7fff;
        end else begin
            k_next = k_half[15:0];
        end
        prod_sat = sat16(48'(mul_p >>> 14));
    end

    // Working registers, commit of the outputs, busy and update
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the small working-register array is reset with the rest so an aborted sequence leaves nothing behind.
            for (int i = 0; i < 2; i++) begin
                wc[i] <= ONE;
                ws[i] <= '0;
            end
            p_reg  <= '0;
            q_reg  <= '0;
            k_reg  <= '0;
            pair   <= PAIR_A;
            cos_a  <= ONE;
            sin_a  <= '0;
            cos_b  <= ONE;
            sin_b  <= '0;
            busy   <= 1'b0;
            update <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (next_state == ROT) begin
                        busy       <= 1'b1;
                        pair       <= PAIR_A;
                        wc[PAIR_A] <= cos_a;
                        ws[PAIR_A] <= sin_a;
                        wc[PAIR_B] <= cos_b;
                        ws[PAIR_B] <= sin_b;
                    end
                end
                ROT: begin
                    for (int i = 0; i < 2; i++) begin
                        wc[i] <= rot_c[i];
                        ws[i] <= rot_s[i];
                    end
                end
                MUL_CC: if (mul_done) p_reg <= mul_p;
                MUL_SS: if (mul_done) q_reg <= mul_p;
                CALC_K: k_reg <= k_next;
                MUL_CK: if (mul_done) wc[pair] <= prod_sat;
                MUL_SK: begin
                    if (mul_done) begin
                        ws[pair] <= prod_sat;
                        if (pair == PAIR_A) begin
                            pair <= PAIR_B;
                        end else begin
                            // Final product bypasses ws so all four outputs land in one edge
                            cos_a  <= wc[PAIR_A];
                            sin_a  <= ws[PAIR_A];
                            cos_b  <= wc[PAIR_B];
                            sin_b  <= prod_sat;
                            update <= 1'b1;
                        end
                    end
                end
                COMMIT: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_donut_angle_stepper.sv
// Self-checking bench for donut_angle_stepper: a frame-level reference model
// (plain integer arithmetic plus a commit-delay counter) is compared with the
// DUT every cycle, with directed literal checks and a multiplier unit test.
module tb_donut_angle_stepper;

    localparam int LAT       = 140;
    localparam int N_FRAMES  = 250;
    localparam int BUDGET    = 60000;
    localparam longint NORM0 = 64'sd268435456;

    typedef struct packed {
        int ca;
        int sa;
        int cb;
        int sb;
    } frame_t;

    logic               clk48;
    logic               rst_n;
    logic               frame_start;
    logic               enable;
    logic signed [15:0] cos_a, sin_a, cos_b, sin_b;
    logic               busy, update;

    logic               mt_start;
    logic signed [15:0] mt_a, mt_b;
    logic signed [31:0] mt_p;
    logic               mt_done;

    int n_checks = 0;
    int n_fail   = 0;

    donut_angle_stepper dut (
        .clk48       (clk48),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .enable      (enable),
        .cos_a       (cos_a),
        .sin_a       (sin_a),
        .cos_b       (cos_b),
        .sin_b       (sin_b),
        .busy        (busy),
        .update      (update)
    );

    mul_serial16 u_mt (
        .clk48 (clk48),
        .rst_n (rst_n),
        .start (mt_start),
        .a     (mt_a),
        .b     (mt_b),
        .p     (mt_p),
        .done  (mt_done)
    );

    initial clk48 = 1'b0;
    always #10 clk48 = ~clk48;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sat(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic void advance(input longint c0, input longint s0, input int sh,
                                    output longint c1, output longint s1);
        longint cr, sr, m, k;
        cr = sat(c0 - (s0 >>> sh));
        sr = sat(s0 + (cr >>> sh));
        m  = (cr * cr + sr * sr) >>> 14;
        k  = (49152 - m) >>> 1;
        if (k < 0) k = 0;
        if (k > 32767) k = 32767;
        c1 = sat((cr * k) >>> 14);
        s1 = sat((sr * k) >>> 14);
    endfunction

    function automatic frame_t next_frame(input frame_t f);
        frame_t r;
        longint c, s;
        advance(longint'(f.ca), longint'(f.sa), 5, c, s);
        r.ca = int'(c);
        r.sa = int'(s);
        advance(longint'(f.cb), longint'(f.sb), 6, c, s);
        r.cb = int'(c);
        r.sb = int'(s);
        return r;
    endfunction

    localparam frame_t RESET_F  = '{ca: 16384, sa: 0, cb: 16384, sb: 0};
    localparam frame_t FRAME1_F = '{ca: 16376, sa: 511, cb: 16382, sb: 255};

    frame_t m_out, m_pend;
    logic   m_busy, m_update;
    int     m_cnt;

    // Timing model: outputs visible LAT cycles after the accepting edge
    always @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            m_out    <= RESET_F;
            m_pend   <= RESET_F;
            m_busy   <= 1'b0;
            m_update <= 1'b0;
            m_cnt    <= 0;
        end else begin
            m_update <= 1'b0;
            if (!m_busy) begin
                if (frame_start && enable) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 1;
                    m_pend <= next_frame(m_out);
                end
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == LAT) begin
                    m_out    <= m_pend;
                    m_update <= 1'b1;
                end
                if (m_cnt + 1 == LAT + 1) m_busy <= 1'b0;
            end
        end
    end

    function automatic logic norm_ok(input logic signed [15:0] c, input logic signed [15:0] s);
        longint n;
        n = longint'(c) * longint'(c) + longint'(s) * longint'(s);
        return (n >= NORM0 - NORM0 / 100) && (n <= NORM0 + NORM0 / 100);
    endfunction

    // Cycle-by-cycle comparison against the model, plus norm check on commit
    always @(negedge clk48) begin
        if (rst_n) begin
            check("cycle", {cos_a, sin_a, cos_b, sin_b, busy, update},
                  {m_out.ca[15:0], m_out.sa[15:0], m_out.cb[15:0], m_out.sb[15:0], m_busy, m_update});
            if (update) begin
                check("norm_a", norm_ok(cos_a, sin_a), 1'b1);
                check("norm_b", norm_ok(cos_b, sin_b), 1'b1);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic pulse_frame();
        @(negedge clk48);
        frame_start = 1'b1;
        @(negedge clk48);
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk48);
        rst_n = 1'b0;
        repeat (2) @(negedge clk48);
        rst_n = 1'b1;
        @(negedge clk48);
    endtask

    task automatic check_outs(input string name, input frame_t f);
        check(name, {cos_a, sin_a, cos_b, sin_b},
              {f.ca[15:0], f.sa[15:0], f.cb[15:0], f.sb[15:0]});
    endtask

    task automatic mul_run(input logic signed [15:0] a, input logic signed [15:0] b,
                           output int lat, output logic signed [31:0] p);
        mt_a     = a;
        mt_b     = b;
        mt_start = 1'b1;
        @(negedge clk48);
        mt_start = 1'b0;
        lat = 1;
        while (!mt_done && lat < 40) begin
            @(negedge clk48);
            lat++;
        end
        p = mt_p;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, cyc, got, lat;
        logic signed [31:0] pr;
        logic signed [15:0] ra, rb;

        frame_start = 1'b0;
        enable      = 1'b1;
        rst_n       = 1'b0;
        mt_start    = 1'b0;
        mt_a        = '0;
        mt_b        = '0;

        // Model pinned against hand-computed first frame
        check("model_frame1", next_frame(RESET_F), FRAME1_F);

        // Reset state
        repeat (3) @(negedge clk48);
        check_outs("reset_outs", RESET_F);
        check("reset_flags", {busy, update}, 2'b00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk48);

        // Single frame latency and values
        pulse_frame();
        check("busy_t1", busy, 1'b1);
        repeat (LAT - 2) @(negedge clk48);
        check_outs("hold_t139", RESET_F);
        check("update_t139", update, 1'b0);
        @(negedge clk48);
        check_outs("frame1_t140", FRAME1_F);
        check("flags_t140", {busy, update}, 2'b11);
        @(negedge clk48);
        check("flags_t141", {busy, update}, 2'b00);

        // frame_start while busy is dropped
        do_reset();
        pulse_frame();
        repeat (48) @(negedge clk48);
        frame_start = 1'b1;
        @(negedge clk48);
        frame_start = 1'b0;
        cnt = 0;
        repeat (250) begin
            @(negedge clk48);
            if (update) cnt++;
        end
        check("dropped_busy_updates", cnt, 1);
        check_outs("dropped_busy_vals", FRAME1_F);

        // enable low freezes the angles
        enable = 1'b0;
        pulse_frame();
        cnt = 0;
        repeat (160) begin
            @(negedge clk48);
            if (busy || update) cnt++;
        end
        check("disabled_busy_cycles", cnt, 0);
        check_outs("disabled_vals", FRAME1_F);
        enable = 1'b1;

        // Reset in the middle of a sequence
        do_reset();
        pulse_frame();
        repeat (68) @(negedge clk48);
        rst_n = 1'b0;
        #1;
        check_outs("midreset_outs", RESET_F);
        check("midreset_flags", {busy, update}, 2'b00);
        repeat (2) @(negedge clk48);
        rst_n = 1'b1;
        cnt = 0;
        repeat (160) begin
            @(negedge clk48);
            if (update) cnt++;
        end
        check("midreset_no_update", cnt, 0);
        pulse_frame();
        repeat (LAT - 1) @(negedge clk48);
        check_outs("after_reset_frame1", FRAME1_F);
        check("after_reset_update", update, 1'b1);
        repeat (3) @(negedge clk48);

        // Randomised long run against the model
        cyc = 0;
        got = 0;
        while (got < N_FRAMES && cyc < BUDGET) begin
            @(negedge clk48);
            frame_start = ($urandom_range(0, 99) < 8);
            enable      = ($urandom_range(0, 9) != 0);
            cyc++;
            if (update) got++;
        end
        frame_start = 1'b0;
        enable      = 1'b1;
        check("long_run_frames", got, N_FRAMES);
        repeat (LAT + 5) @(negedge clk48);

        // Multiplier unit test
        mul_run(-16'sd32768, -16'sd32768, lat, pr);
        check("mul_min_min_p", pr, 32'sd1073741824);
        check("mul_min_min_lat", lat, 16);
        mul_run(-16'sd1, 16'sd32767, lat, pr);
        check("mul_m1_max_p", pr, -32'sd32767);
        check("mul_m1_max_lat", lat, 16);
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            mul_run(ra, rb, lat, pr);
            check("mul_rand_p", pr, 32'(longint'(ra) * longint'(rb)));
            check("mul_rand_lat", lat, 16);
        end
        // Restart while running
        mt_a     = 16'sd7;
        mt_b     = 16'sd9;
        mt_start = 1'b1;
        @(negedge clk48);
        mt_start = 1'b0;
        repeat (4) @(negedge clk48);
        mul_run(-16'sd300, 16'sd123, lat, pr);
        check("mul_restart_p", pr, -32'sd36900);
        check("mul_restart_lat", lat, 16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
